// File: rtl/rst_gen_pkg.sv
// rst_gen_pkg: shared FSM state, reset-cause encodings and counter-width helper for rst_gen
package rst_gen_pkg;
  typedef enum logic [1:0] {HOLD, RELEASE, IDLE} state_t;
  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_BTN  = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;
  localparam logic [1:0] CAUSE_WDOG = 2'd3;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus stability-window debouncer for an active-low push button
// Ports: clk, rst (async, active-high), btn_n (raw active-low button), pressed (debounced, active-high)
module btn_debounce
  import rst_gen_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed
);
  localparam int W = cnt_w(DEB_CYCLES);
  logic s1_q, s2_q, deb_q, deb_d;
  logic [W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_n;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end
  // Any clock where the synchronized value agrees with the debounced one clears the count,
  // so a flip needs DEB_CYCLES consecutive disagreeing samples; the count never exceeds DEB_CYCLES-1.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == W'(DEB_CYCLES - 1)) deb_d = s2_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  assign pressed = ~deb_q;
endmodule

// File: rtl/rst_gen.sv
// rst_gen: reset generator with debounced button, software and watchdog requests and staged release
// Ports: clk, rst (async, active-high), btn_n (raw active-low button), sw_req (1-cycle pulse),
//        wdog_req (level), rst_out[NUM_OUT] (registered domain resets), busy (state != IDLE),
//        cause (last reset cause: 0 power-on, 1 button, 2 software, 3 watchdog)
module rst_gen
  import rst_gen_pkg::*;
#(
  parameter int DEB_CYCLES  = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int STAGE_GAP   = 8,
  parameter int NUM_OUT     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_n,
  input  logic               sw_req,
  input  logic               wdog_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               busy,
  output logic [1:0]         cause
);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int GW = cnt_w(STAGE_GAP);
  localparam int IW = cnt_w(NUM_OUT);
  state_t state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [GW-1:0] stage_cnt_q, stage_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic [1:0] cause_q, cause_d;
  logic pressed, req;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .pressed(pressed)
  );
  assign req = wdog_req | sw_req | pressed;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      stage_cnt_q <= '0;
      idx_q       <= '0;
      rst_out_q   <= '1;
      cause_q     <= CAUSE_POR;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      idx_q       <= idx_d;
      rst_out_q   <= rst_out_d;
      cause_q     <= cause_d;
    end
  end
  // A request always wins: it re-enters HOLD from anywhere with a fresh count, but only an
  // entry from outside HOLD records a new cause. idx_q names the next output to release.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stage_cnt_d = stage_cnt_q;
    idx_d       = idx_q;
    rst_out_d   = rst_out_q;
    cause_d     = cause_q;
    if (req) begin
      state_d     = HOLD;
      hold_cnt_d  = '0;
      stage_cnt_d = '0;
      rst_out_d   = '1;
      if (state_q != HOLD) cause_d = wdog_req ? CAUSE_WDOG : pressed ? CAUSE_BTN : CAUSE_SW;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
            state_d      = (NUM_OUT > 1) ? RELEASE : IDLE;
            rst_out_d[0] = 1'b0;
            stage_cnt_d  = '0;
            idx_d        = IW'(1);
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (stage_cnt_q == GW'(STAGE_GAP - 1)) begin
            rst_out_d[idx_q] = 1'b0;
            stage_cnt_d      = '0;
            if (idx_q == IW'(NUM_OUT - 1)) state_d = IDLE;
            else idx_d = idx_q + 1'b1;
          end else begin
            stage_cnt_d = stage_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  assign rst_out = rst_out_q;
  assign busy    = state_q != IDLE;
  assign cause   = cause_q;
endmodule

// File: tb/tb_rst_gen.sv
// tb_rst_gen: randomized and directed self-checking bench for rst_gen against a time-based reference model
module tb_rst_gen;
  localparam int DEB = 16, HOLD = 64, GAP = 8, N = 3;
  logic clk = 1'b0, rst = 1'b1, btn_n = 1'b1, sw_req = 1'b0, wdog_req = 1'b0;
  logic [N-1:0] rst_out;
  logic busy;
  logic [1:0] cause;
  int tests = 0, fails = 0;
  int t = 0, last = 0, mk = 0;
  bit bh[$];
  bit deb_rel = 1'b1, m_req, m_stable;
  logic [N-1:0] m_out = '1;
  logic m_busy = 1'b1;
  logic [1:0] m_cause = 2'd0;

  rst_gen #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .NUM_OUT(N)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .sw_req(sw_req), .wdog_req(wdog_req),
    .rst_out(rst_out), .busy(busy), .cause(cause)
  );

  initial forever #10 clk = ~clk;

  function automatic bit btn_at(int e);
    return (e >= 1) ? bh[e-1] : 1'b1;
  endfunction

  // Reference: t counts edges since reset, last is the latest edge that saw a request
  // (reset counts as edge 0). Outputs follow purely from the distance t-last.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      t = 0; last = 0; bh.delete(); deb_rel = 1'b1; m_cause = 2'd0;
    end else begin
      t++;
      bh.push_back(btn_n);
      m_req = wdog_req | sw_req | !deb_rel;
      if (m_req) begin
        if (t - 1 - last >= HOLD) m_cause = wdog_req ? 2'd3 : !deb_rel ? 2'd1 : 2'd2;
        last = t;
      end
      m_stable = 1'b1;
      for (int i = 0; i < DEB; i++) if (btn_at(t - 2 - i) == deb_rel) m_stable = 1'b0;
      if (m_stable) deb_rel = !deb_rel;
    end
    mk = t - last;
    for (int i = 0; i < N; i++) m_out[i] = !(mk >= HOLD && mk - HOLD >= i * GAP);
    m_busy = mk < HOLD + (N - 1) * GAP;
  end

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic cmp_model();
    check("model_rst_out", 8'(rst_out), 8'(m_out));
    check("model_busy", 8'(busy), 8'(m_busy));
    check("model_cause", 8'(cause), 8'(m_cause));
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      cmp_model();
    end
  endtask

  task automatic wait_out(logic [N-1:0] v, string name);
    int n = 0;
    while (rst_out !== v && n < 300) begin
      tick(1);
      n++;
    end
    check(name, 8'(rst_out), 8'(v));
  endtask

  task automatic por_seq(string tag);
    tick(HOLD - 1);
    check({tag, "_hold"}, 8'(rst_out), 8'b111);
    tick(1);
    check({tag, "_stage0"}, 8'(rst_out), 8'b110);
    tick(GAP);
    check({tag, "_stage1"}, 8'(rst_out), 8'b100);
    tick(GAP);
    check({tag, "_stage2"}, 8'(rst_out), 8'b000);
    check({tag, "_busy"}, 8'(busy), 8'd0);
    check({tag, "_cause"}, 8'(cause), 8'd0);
  endtask

  initial begin
    int btn_run, wd_run;
    repeat (3) @(negedge clk);
    check("reset_rst_out", 8'(rst_out), 8'b111);
    check("reset_busy", 8'(busy), 8'd1);
    check("reset_cause", 8'(cause), 8'd0);
    rst = 1'b0;
    por_seq("por");
    // Short bounces never survive the debounce window.
    for (int b = 0; b < 5; b++) begin
      btn_n = 1'b0;
      tick(5);
      btn_n = 1'b1;
      tick(5);
    end
    tick(20);
    check("bounce_rst_out", 8'(rst_out), 8'b000);
    check("bounce_busy", 8'(busy), 8'd0);
    // 40-clock press: reset at 2+16+1 clocks, release 64 clocks after debounced release.
    btn_n = 1'b0;
    tick(18);
    check("btn_pre", 8'(rst_out), 8'b000);
    tick(1);
    check("btn_assert", 8'(rst_out), 8'b111);
    check("btn_cause", 8'(cause), 8'd1);
    tick(21);
    btn_n = 1'b1;
    tick(81);
    check("btn_hold_end", 8'(rst_out), 8'b111);
    tick(1);
    check("btn_release", 8'(rst_out), 8'b110);
    // Software pulse mid-release restarts the hold.
    wait_out(3'b100, "sw_wait_stage");
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    check("sw_assert", 8'(rst_out), 8'b111);
    check("sw_cause", 8'(cause), 8'd2);
    tick(HOLD - 1);
    check("sw_hold_end", 8'(rst_out), 8'b111);
    tick(1);
    check("sw_release", 8'(rst_out), 8'b110);
    // Simultaneous software+watchdog: watchdog wins and holds for 100 clocks.
    wait_out(3'b000, "wd_wait_idle");
    sw_req = 1'b1;
    wdog_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    check("wd_assert", 8'(rst_out), 8'b111);
    check("wd_cause", 8'(cause), 8'd3);
    tick(99);
    wdog_req = 1'b0;
    tick(HOLD - 1);
    check("wd_hold_end", 8'(rst_out), 8'b111);
    check("wd_cause_kept", 8'(cause), 8'd3);
    tick(1);
    check("wd_release", 8'(rst_out), 8'b110);
    // Asynchronous reset mid-release.
    #3 rst = 1'b1;
    #1;
    check("async_rst_out", 8'(rst_out), 8'b111);
    check("async_cause", 8'(cause), 8'd0);
    check("async_busy", 8'(busy), 8'd1);
    @(negedge clk);
    rst = 1'b0;
    por_seq("por2");
    // Randomized requests checked every cycle against the model.
    btn_run = 100;
    wd_run = 0;
    for (int c = 0; c < 4000; c++) begin
      sw_req = ($urandom_range(0, 149) == 0);
      if (wd_run > 0) wd_run--;
      else if ($urandom_range(0, 399) == 0) wd_run = $urandom_range(1, 20);
      wdog_req = (wd_run > 0);
      if (btn_run > 0) btn_run--;
      else begin
        btn_n = !btn_n;
        btn_run = btn_n ? $urandom_range(20, 400) : $urandom_range(1, 40);
      end
      tick(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rst_gen.md
RST_GEN -- requirements
Module: rst_gen

Interface
REQ-001 Parameters SHALL be: DEB_CYCLES, default 16, button debounce stability window in clocks; HOLD_CYCLES, default 64, minimum reset assertion in clocks; STAGE_GAP, default 8, clocks between staged releases; NUM_OUT, default 3, number of reset outputs.
REQ-002 Port clk SHALL be input, 1 bit: the 50MHz system clock; all logic is on posedge clk.
REQ-003 Port rst SHALL be input, 1 bit: asynchronous, active-high reset. This is already decided.
REQ-004 Port btn_n SHALL be input, 1 bit: raw asynchronous push button, active-low, bouncing.
REQ-005 Port sw_req SHALL be input, 1 bit: synchronous one-cycle software reset request pulse.
REQ-006 Port wdog_req SHALL be input, 1 bit: synchronous level-sensitive watchdog reset request.
REQ-007 Port rst_out SHALL be output, NUM_OUT bits: generated active-high domain resets, all registered.
REQ-008 Port busy SHALL be output, 1 bit: high whenever the state is not IDLE.
REQ-009 Port cause SHALL be output, 2 bits: last reset cause; 0 means power-on, 1 button, 2 software, 3 watchdog.

Function
REQ-010 btn_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 The debounced button state SHALL change only after the synchronized value has differed from it for DEB_CYCLES consecutive clocks; any reversion during that window SHALL clear the count.
REQ-012 The request signal req SHALL be defined as wdog_req OR sw_req OR the debounced button being pressed.
REQ-013 The FSM SHALL have the states HOLD, RELEASE and IDLE.
REQ-014 HOLD: all rst_out bits SHALL be 1; hold_cnt SHALL increment each clock while req is low and clear to 0 while req is high.
REQ-015 The FSM SHALL go from HOLD to RELEASE on the clock where hold_cnt reaches HOLD_CYCLES-1 with req low.
REQ-016 RELEASE: rst_out[0] SHALL deassert on entry, and rst_out[k] SHALL deassert k*STAGE_GAP clocks after rst_out[0].
REQ-017 Deassertions in RELEASE SHALL occur in ascending index order only.
REQ-018 The FSM SHALL go from RELEASE to IDLE on the clock where rst_out[NUM_OUT-1] deasserts.
REQ-019 In IDLE or RELEASE, req high on clock edge N SHALL give all rst_out = 1 and state HOLD with hold_cnt = 0 after edge N+1; latency is exactly one clock.
REQ-020 A button held indefinitely or wdog_req held high SHALL keep the FSM in HOLD indefinitely.
REQ-021 cause SHALL update on each entry to HOLD caused by req, with priority watchdog > button > software when requests are simultaneous.
REQ-022 A request arriving while already in HOLD SHALL restart the hold count but SHALL NOT change cause.
REQ-023 Counter widths SHALL be $clog2 of the respective parameter, with a minimum of 1 bit.
REQ-024 Counters SHALL saturate and never wrap.

Reset
REQ-025 rst high SHALL immediately and asynchronously set: rst_out all ones, state HOLD, hold_cnt 0, stage counter 0, cause 0, busy 1, synchronizer flops 1 (released), debounced state released, debounce counter 0.
REQ-026 On rst deassertion, the FSM SHALL run a full HOLD_CYCLES hold followed by the staged release.

Structure
REQ-027 A shared package rst_gen_pkg SHALL hold the state enum (HOLD, RELEASE, IDLE) and the cause encodings CAUSE_POR, CAUSE_BTN, CAUSE_SW and CAUSE_WDOG.
REQ-028 The synchronizer and debouncer SHALL be one sub-module, btn_debounce, parameterized by DEB_CYCLES, with output pressed.

Verification
REQ-029 Power-on: deassert rst at t0 with no requests -> rst_out = 3'b111 for 64 clocks, then 3'b110, 3'b100 after +8 clocks, 3'b000 after +16 clocks; busy falls with the last release; cause = 0.
REQ-030 Button bounce: in IDLE, toggle btn_n low for 5 clocks, 5 times -> no reset.
REQ-031 Button press: hold btn_n low for 40 clocks -> rst_out = 3'b111 at 2+16+1 clocks after the fall; release then follows 64 clocks after the debounced release; cause = 1.
REQ-032 Software request: one-cycle sw_req during RELEASE while rst_out = 3'b100 -> rst_out = 3'b111 on the next clock and the hold restarts; cause = 2.
REQ-033 Simultaneous requests: sw_req and wdog_req on the same clock, with wdog_req held 100 clocks -> cause = 3; rst_out stays 3'b111 until 64 clocks after wdog_req falls.
REQ-034 Mid-operation reset: pulse rst during RELEASE -> rst_out = 3'b111 asynchronously and cause = 0, then the full power-on sequence repeats.
